// File: rtl/switch_sequencer_pkg.sv
// Shared types and constants for the picoMips switch-interface sequencer.
package switch_sequencer_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned SW_W         = 10;
  localparam int unsigned SW_NRESET    = 9;
  localparam int unsigned SW_HANDSHAKE = 8;
  localparam int unsigned SW_DATA_MSB  = 7;

  typedef enum logic [2:0] {
    CPU_RST,
    IDLE,
    PRESENT,
    RELEASE,
    SETTLE,
    CAPTURE
  } state_e;

  // Larger of two unsigned values, used to size the shared down-counter.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sw_fifo.sv
// Circular-buffer operand FIFO with synchronous reset and registered empty flag.
module sw_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_c,
  output logic             empty_o,
  output logic             full_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok    = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok     = pop_i && (count_q != '0);
  assign head_c     = mem_q[rd_ptr_q];
  assign empty_o    = empty_q;
  assign full_nxt_c = (count_d == CNT_W'(DEPTH));

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/switch_sequencer.sv
// Drives picoMips SW pins from an operand FIFO and samples LED after each group.
module switch_sequencer
  import switch_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned HOLD_CYCLES      = 16,
  parameter int unsigned GAP_CYCLES       = 16,
  parameter int unsigned OPS_PER_RESULT   = 2,
  parameter int unsigned RESULT_DELAY     = 64,
  parameter int unsigned CPU_RESET_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [SW_W-1:0]   SW,
  input  logic [DATA_W-1:0] LED,
  output logic [DATA_W-1:0] Result,
  output logic              ResultValid,
  output logic              Busy
);

  localparam int unsigned CNT_MAX = max2(max2(HOLD_CYCLES, GAP_CYCLES),
                                         max2(RESULT_DELAY, CPU_RESET_CYCLES));
  localparam int unsigned CNT_W   = max2(1, $clog2(CNT_MAX));
  localparam int unsigned OPC_W   = max2(1, $clog2(OPS_PER_RESULT + 1));

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [SW_W-1:0]   sw_q, sw_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rvalid_q, rvalid_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic              pop_c;
  logic              push_c;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full_nxt;

  assign push_c      = InValid && ready_q;
  assign InReady     = ready_q;
  assign SW          = sw_q;
  assign Result      = result_q;
  assign ResultValid = rvalid_q;
  assign Busy        = busy_q;

  sw_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .push_i     (push_c),
    .wdata_i    (InData),
    .pop_i      (pop_c),
    .head_c     (fifo_head),
    .empty_o    (fifo_empty),
    .full_nxt_c (fifo_full_nxt)
  );

  // Sequencer next-state, counters and registered-output next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opc_d    = opc_q;
    sw_d     = sw_q;
    result_d = result_q;
    pop_c    = 1'b0;

    case (state_q)
      CPU_RST: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      IDLE: begin
        if (!fifo_empty) begin
          pop_c                 = 1'b1;
          sw_d[SW_DATA_MSB:0]   = fifo_head;
          state_d               = PRESENT;
          cnt_d                 = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      PRESENT: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          if (opc_q == OPC_W'(OPS_PER_RESULT - 1)) begin
            opc_d   = '0;
            state_d = SETTLE;
            cnt_d   = CNT_W'(RESULT_DELAY - 1);
          end else begin
            opc_d   = opc_q + OPC_W'(1);
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d  = CAPTURE;
          result_d = LED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = CPU_RST;
        cnt_d   = CNT_W'(CPU_RESET_CYCLES - 1);
      end
    endcase

    // Output bits follow the state being entered so they align with it.
    sw_d[SW_NRESET]    = (state_d != CPU_RST);
    sw_d[SW_HANDSHAKE] = (state_d == PRESENT);
    rvalid_d           = (state_d == CAPTURE);
    busy_d             = (state_d != IDLE);
    ready_d            = !fifo_full_nxt;
  end

  // State, counter and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= CPU_RST;
      cnt_q    <= CNT_W'(CPU_RESET_CYCLES - 1);
      opc_q    <= '0;
      sw_q     <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opc_q    <= opc_d;
      sw_q     <= sw_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer with default parameters.
module tb_switch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] sw;
  logic [7:0] led;
  logic [7:0] result;
  logic       rvalid;
  logic       busy;
  logic       rv_prev = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  switch_sequencer dut (
    .Clock       (clk),
    .Reset       (rst),
    .InData      (in_data),
    .InValid     (in_valid),
    .InReady     (in_ready),
    .SW          (sw),
    .LED         (led),
    .Result      (result),
    .ResultValid (rvalid),
    .Busy        (busy)
  );

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [9:0] exp_sw;
    logic       exp_busy;
    logic       exp_ready;
    logic       exp_rv;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rvalid === 1'b1) check("rv_back_to_back", 32'(rv_prev), 32'h0);
    rv_prev = rvalid;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [9:0] s,
                              input logic b, input logic r);
    vec_t x;
    x.rst = 1'b0; x.valid = v; x.data = d; x.exp_sw = s;
    x.exp_busy = b; x.exp_ready = r; x.exp_rv = 1'b0;
    return x;
  endfunction

  logic [7:0] seen [$];
  logic       prev_hs;
  int         rv_count;
  int         rv_at;

  initial begin
    // Reset-release table: cycles c0..c6 after Reset drops, pushing 0x05 and 0xFA.
    vecs[0] = mk(1'b0, 8'h00, 10'h000, 1'b1, 1'b0);
    vecs[1] = mk(1'b0, 8'h00, 10'h000, 1'b1, 1'b1);
    vecs[2] = mk(1'b0, 8'h00, 10'h000, 1'b1, 1'b1);
    vecs[3] = mk(1'b0, 8'h00, 10'h000, 1'b1, 1'b1);
    vecs[4] = mk(1'b0, 8'h00, 10'h200, 1'b0, 1'b1);
    vecs[5] = mk(1'b1, 8'h05, 10'h200, 1'b0, 1'b1);
    vecs[6] = mk(1'b1, 8'hFA, 10'h200, 1'b0, 1'b1);

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; led = 8'h3C;
    step(); step();
    check("rst_sw", 32'(sw), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_rv", 32'(rvalid), 32'h0);
    check("rst_result", 32'(result), 32'h0);

    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst; in_valid = vecs[i].valid; in_data = vecs[i].data;
      check($sformatf("vec%0d_sw", i), 32'(sw), 32'(vecs[i].exp_sw));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_rv", i), 32'(rvalid), 32'(vecs[i].exp_rv));
      step();
    end
    in_valid = 1'b0;

    // Single group: pop of 0x05 was at c6, so k=0 is c7.
    for (int k = 0; k <= 130; k++) begin
      logic [9:0] es;
      if (k <= 15)      es = 10'h305;
      else if (k <= 32) es = 10'h205;
      else if (k <= 48) es = 10'h3FA;
      else              es = 10'h2FA;
      check("grp_sw", 32'(sw), 32'(es));
      check("grp_rv", 32'(rvalid), 32'(k == 129));
      check("grp_busy", 32'(busy), 32'(!(k == 32 || k == 130)));
      if (k == 129) check("grp_result", 32'(result), 32'h3C);
      step();
    end

    // Starvation mid-group: one operand, 100 idle cycles, then the second.
    in_data = 8'h11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 100; i++) begin
      check("starve_hs", 32'(sw[8]), 32'(i >= 2 && i <= 17));
      check("starve_rv", 32'(rvalid), 32'h0);
      if (i >= 34) check("starve_idle", 32'(busy), 32'h0);
      step();
    end
    led = 8'h77; in_data = 8'h22; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rv_count = 0;
    for (int i = 101; i <= 230; i++) begin
      check("starve2_hs", 32'(sw[8]), 32'(i >= 102 && i <= 117));
      if (i == 102) check("starve2_data", 32'(sw[7:0]), 32'h22);
      check("starve2_rv", 32'(rvalid), 32'(i == 198));
      if (rvalid === 1'b1) rv_count++;
      if (i == 198) check("starve2_result", 32'(result), 32'h77);
      step();
    end
    check("starve_rv_count", 32'(rv_count), 32'h1);

    // FIFO full: while 0x30 is presented, try to push five operands.
    in_data = 8'h30; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("full_first", 32'(sw), 32'h330);
    for (int j = 0; j < 5; j++) begin
      in_data = 8'h41 + 8'(j); in_valid = 1'b1;
      check($sformatf("full_ready%0d", j), 32'(in_ready), 32'(j < 4));
      step();
    end
    in_valid = 1'b0;
    check("full_ready_after", 32'(in_ready), 32'h0);
    prev_hs = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (sw[8] && !prev_hs) seen.push_back(sw[7:0]);
      prev_hs = sw[8];
      if (n == 33) check("full_ready_back", 32'(in_ready), 32'h1);
      step();
    end
    check("full_seen_count", 32'(seen.size()), 32'h4);
    for (int j = 0; j < 4 && j < seen.size(); j++)
      check($sformatf("full_order%0d", j), 32'(seen[j]), 32'h41 + 32'(j));

    // Reset mid-PRESENT with two operands still queued.
    for (int j = 0; j < 3; j++) begin
      in_data = 8'h51 + 8'(j); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("mid_present", 32'(sw), 32'h351);
    step();
    rst = 1'b1;
    step();
    check("mid_rst_sw", 32'(sw), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h1);
    check("mid_rst_rv", 32'(rvalid), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("mid_seq_sw", 32'(sw), (i < 4) ? 32'h0 : 32'h200);
      check("mid_seq_busy", 32'(busy), 32'(i < 4));
      check("mid_seq_rv", 32'(rvalid), 32'h0);
      step();
    end

    // Operand count restarts at zero after Reset: result follows the second operand.
    led = 8'h5A;
    in_data = 8'h61; in_valid = 1'b1;
    step();
    in_data = 8'h62;
    step();
    in_valid = 1'b0;
    rv_at = -1;
    for (int h = 2; h < 200 && rv_at < 0; h++) begin
      if (rvalid === 1'b1) rv_at = h;
      else step();
    end
    check("post_rst_rv_cycle", 32'(rv_at), 32'd131);
    check("post_rst_result", 32'(result), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
